iir_sequencer: RTL

//  Control FSM for the 2nd-order IIR filter datapath. Per accepted ADC sample it issues one

---
 rtl/iir_sequencer_pkg.sv | 30 +++
 rtl/iir_sequencer_if.sv | 30 +++
 rtl/iir_sequencer_pulse_delay.sv | 32 +++
 rtl/iir_sequencer.sv | 125 ++++++++++++
 4 files changed

// File: rtl/iir_sequencer_pkg.sv
// Shared definitions for the IIR filter sequencer: FSM states, tap indices and
// the default filter geometry.
package iir_sequencer_pkg;

  localparam int TAPS_DEF    = 5;
  localparam int MAC_LAT_DEF = 2;
  localparam int CNT_W       = 4;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SHIFT = 3'd1,
    ST_MAC   = 3'd2,
    ST_DRAIN = 3'd3,
    ST_OUT   = 3'd4
  } state_e;

  // Tap order is shared with the coefficient ROM / operand mux.
  typedef enum logic [2:0] {
    TAP_B0 = 3'd0,
    TAP_B1 = 3'd1,
    TAP_B2 = 3'd2,
    TAP_A1 = 3'd3,
    TAP_A2 = 3'd4
  } tap_e;

  function automatic int sel_width(input int taps);
    return (taps > 1) ? $clog2(taps) : 1;
  endfunction

endpackage

// File: rtl/iir_sequencer_if.sv
// Handshake and control bundle between the sequencer, the ADC capture side,
// the Shift_Reg + MAC datapath and the DAC side.
interface iir_sequencer_if
  import iir_sequencer_pkg::*;
#(
  parameter int SEL_W = sel_width(TAPS_DEF)
) ();

  logic             sample_valid;
  logic             sample_ready;
  logic             shift;
  logic             acc_clr;
  logic [SEL_W-1:0] sel;
  logic             acc_en;
  logic             y_valid;
  logic             y_ready;
  logic             busy;
  logic             overrun;

  modport master (
    input  sample_valid, y_ready,
    output sample_ready, shift, acc_clr, sel, acc_en, y_valid, busy, overrun
  );

  modport slave (
    output sample_valid, y_ready,
    input  sample_ready, shift, acc_clr, sel, acc_en, y_valid, busy, overrun
  );

endinterface

// File: rtl/iir_sequencer_pulse_delay.sv
// Fixed-length 1-bit delay line with synchronous reset; D==0 passes the input
// straight through.
module iir_sequencer_pulse_delay #(
  parameter int D = 2
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic d_i,
  output logic q_o
);

  generate
    if (D == 0) begin : g_wire
      logic unused_clk_rst;
      assign unused_clk_rst = clk_i | reset_i;
      assign q_o = d_i;
    end else begin : g_chain
      logic [D-1:0] chain_q;

      always_ff @(posedge clk_i) begin
        if (reset_i) begin
          chain_q <= '0;
        end else begin
          chain_q <= (chain_q << 1) | D'(d_i);
        end
      end

      assign q_o = chain_q[D-1];
    end
  endgenerate

endmodule

// File: rtl/iir_sequencer.sv
// Control FSM for the 2nd-order IIR datapath: shift/clear per sample, step the
// operand mux through TAPS products, align acc_en to the multiplier, hand y to the DAC.
module iir_sequencer
  import iir_sequencer_pkg::*;
#(
  parameter int TAPS    = TAPS_DEF,
  parameter int MAC_LAT = MAC_LAT_DEF
) (
  input  logic           clk_i,
  input  logic           reset_i,
  iir_sequencer_if.master bus
);

  localparam int               SEL_W      = sel_width(TAPS);
  localparam logic [CNT_W-1:0] LAST_TAP   = CNT_W'(TAPS - 1);
  localparam logic [CNT_W-1:0] LAST_DRAIN = CNT_W'((MAC_LAT > 0) ? (MAC_LAT - 1) : 0);
  localparam logic [SEL_W-1:0] LAST_SEL   = SEL_W'(TAPS - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic             sample_ready_q;
  logic             shift_q;
  logic             acc_clr_q;
  logic             issue_q;
  logic             y_valid_q;
  logic             busy_q;
  logic             overrun_q, overrun_d;
  logic             acc_en_s;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.sample_valid) state_d = ST_SHIFT;
        else                  state_d = ST_IDLE;
      end
      ST_SHIFT: begin
        state_d = ST_MAC;
        cnt_d   = CNT_W'(TAP_B0);
      end
      ST_MAC: begin
        if (cnt_q == LAST_TAP) begin
          cnt_d   = '0;
          state_d = (MAC_LAT == 0) ? ST_OUT : ST_DRAIN;
        end else begin
          cnt_d   = cnt_q + CNT_W'(1);
        end
      end
      ST_DRAIN: begin
        if (cnt_q == LAST_DRAIN) begin
          cnt_d   = '0;
          state_d = ST_OUT;
        end else begin
          cnt_d   = cnt_q + CNT_W'(1);
        end
      end
      ST_OUT: begin
        if (bus.y_ready) state_d = ST_IDLE;
        else             state_d = ST_OUT;
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Outputs are decoded from the next state so every port comes straight from a flop.
  always_comb begin
    sel_d = '0;
    if (state_d == ST_MAC) begin
      sel_d = SEL_W'(cnt_d);
    end else if (state_d == ST_DRAIN) begin
      sel_d = LAST_SEL;
    end else begin
      sel_d = '0;
    end
    overrun_d = overrun_q | (bus.sample_valid & ~sample_ready_q);
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q        <= ST_IDLE;
      cnt_q          <= '0;
      sel_q          <= '0;
      sample_ready_q <= 1'b1;
      shift_q        <= 1'b0;
      acc_clr_q      <= 1'b0;
      issue_q        <= 1'b0;
      y_valid_q      <= 1'b0;
      busy_q         <= 1'b0;
      overrun_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      sel_q          <= sel_d;
      sample_ready_q <= (state_d == ST_IDLE);
      shift_q        <= (state_d == ST_SHIFT);
      acc_clr_q      <= (state_d == ST_SHIFT);
      issue_q        <= (state_d == ST_MAC);
      y_valid_q      <= (state_d == ST_OUT);
      busy_q         <= (state_d != ST_IDLE);
      overrun_q      <= overrun_d;
    end
  end

  iir_sequencer_pulse_delay #(.D(MAC_LAT)) u_acc_en_dly (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .d_i     (issue_q),
    .q_o     (acc_en_s)
  );

  assign bus.sample_ready = sample_ready_q;
  assign bus.shift        = shift_q;
  assign bus.acc_clr      = acc_clr_q;
  assign bus.sel          = sel_q;
  assign bus.acc_en       = acc_en_s;
  assign bus.y_valid      = y_valid_q;
  assign bus.busy         = busy_q;
  assign bus.overrun      = overrun_q;

endmodule
